aes_decrypt_core: RTL



---
 rtl/aes_decrypt_core.sv | 74 +++++++
 1 files changed

// File: rtl/aes_decrypt_core.sv
// Word-serial inverse of the XOR-based AES encryption path: plaintext = ciphertext XOR key,
// one 32-bit word per cycle, result held on a valid/ready handshake.
module aes_decrypt_core (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    output logic [127:0] plaintext,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t       state, state_nxt;
    logic [1:0]   cnt;
    logic [127:0] ct_reg;
    logic [127:0] key_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == 2'd3) state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Any start seen outside IDLE is rejected, including one coinciding with the handoff.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= 2'd0;
            ct_reg    <= '0;
            key_reg   <= '0;
            plaintext <= '0;
            overrun   <= 1'b0;
        end else begin
            overrun <= start && (state != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        ct_reg  <= ciphertext;
                        key_reg <= key;
                        cnt     <= 2'd0;
                    end
                end
                RUN: begin
                    plaintext[{cnt, 5'b0} +: 32] <= ct_reg[{cnt, 5'b0} +: 32] ^ key_reg[{cnt, 5'b0} +: 32];
                    cnt <= cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == HOLD);

endmodule
